// File: rtl/quickq_deq_engine_if.sv
// quickq_deq_engine_if: client handshake, length update and BRAM port of the QuickQ dequeue engine
interface quickq_deq_engine_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic              deq_req;
   logic              deq_ready;
   logic              deq_valid;
   logic [DATA_W-1:0] deq_data;
   logic              deq_empty;
   logic              busy;
   logic [ADDR_W:0]   len_in;
   logic [ADDR_W:0]   len_out;
   logic              len_we;
   logic [ADDR_W-1:0] bram_addr;
   logic              bram_rd_en;
   logic [DATA_W-1:0] bram_rdata;
   logic              bram_we;
   logic [DATA_W-1:0] bram_wdata;
   modport master (
      output deq_req, deq_ready, len_in, bram_rdata,
      input  deq_valid, deq_data, deq_empty, busy, len_out, len_we,
             bram_addr, bram_rd_en, bram_we, bram_wdata
   );
   modport slave (
      input  deq_req, deq_ready, len_in, bram_rdata,
      output deq_valid, deq_data, deq_empty, busy, len_out, len_we,
             bram_addr, bram_rd_en, bram_we, bram_wdata
   );
endinterface

// File: rtl/quickq_deq_engine.sv
// quickq_deq_engine: pops the head of the sorted BRAM array and shifts the remaining entries down
module quickq_deq_engine #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input logic                 clk,
   input logic                 rst_n,
   quickq_deq_engine_if.slave  q
);
   typedef enum logic [2:0] {IDLE, HEAD_RD, HEAD_CAP, SHIFT_RD, SHIFT_WR, UPDATE, RESP} state_t;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   state_t            state, nxt;
   logic [ADDR_W:0]   len, idx, len_sat;
   logic [DATA_W-1:0] data_q;
   logic              valid_q, empty_q;
   assign len_sat = q.len_in > DEPTH_L ? DEPTH_L : q.len_in;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         len     <= '0;
         idx     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         empty_q <= 1'b0;
      end else begin
         state   <= nxt;
         empty_q <= state == IDLE && q.deq_req && len_sat == '0;
         // valid trails RESP entry by one cycle and clears on the accepting handshake
         valid_q <= state == RESP && !(valid_q && q.deq_ready);
         if (state == IDLE && q.deq_req) len <= len_sat;
         if (state == HEAD_CAP) begin
            data_q <= q.bram_rdata;
            idx    <= ONE;
         end
         if (state == SHIFT_WR) idx <= idx + 1'b1;
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     nxt = q.deq_req && len_sat != '0 ? HEAD_RD : IDLE;
         HEAD_RD:  nxt = HEAD_CAP;
         HEAD_CAP: nxt = len == ONE ? UPDATE : SHIFT_RD;
         SHIFT_RD: nxt = SHIFT_WR;
         SHIFT_WR: nxt = idx == len - 1'b1 ? UPDATE : SHIFT_RD;
         UPDATE:   nxt = RESP;
         RESP:     nxt = valid_q && q.deq_ready ? IDLE : RESP;
         default:  nxt = IDLE;
      endcase
   end
   assign q.busy       = state != IDLE;
   assign q.deq_valid  = valid_q;
   assign q.deq_data   = data_q;
   assign q.deq_empty  = empty_q;
   assign q.len_we     = state == UPDATE;
   assign q.len_out    = state == UPDATE ? len - 1'b1 : '0;
   assign q.bram_rd_en = state == HEAD_RD || state == SHIFT_RD;
   assign q.bram_we    = state == SHIFT_WR;
   // the word read at idx in SHIFT_RD is written back one slot lower in SHIFT_WR
   assign q.bram_addr  = state == SHIFT_RD ? ADDR_W'(idx) :
                         state == SHIFT_WR ? ADDR_W'(idx - 1'b1) : '0;
   assign q.bram_wdata = state == SHIFT_WR ? q.bram_rdata : '0;
endmodule

// File: tb/tb_quickq_deq_engine.sv
// tb_quickq_deq_engine: directed dequeue scenarios against a behavioural BRAM
module tb_quickq_deq_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pl_we = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;
   logic [31:0] mem [1024];
   int nchk = 0, nerr = 0;
   int rd_cnt = 0, wr_cnt = 0, lwe_cnt = 0, lout = -1;
   int ovl = 0, addr_err = 0, idle_err = 0;
   int cur_len = 0;
   int r0, w0, l0, bad;
   quickq_deq_engine_if #(.DATA_W(32), .ADDR_W(10)) q ();
   quickq_deq_engine #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024)) dut (.clk(clk), .rst_n(rst_n), .q(q));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (q.bram_we) mem[q.bram_addr] <= q.bram_wdata;
      if (q.bram_rd_en) q.bram_rdata <= mem[q.bram_addr];
   end
   always @(posedge clk) begin
      if (q.bram_rd_en) rd_cnt <= rd_cnt + 1;
      if (q.bram_we) wr_cnt <= wr_cnt + 1;
      if (q.len_we) begin
         lwe_cnt <= lwe_cnt + 1;
         lout    <= int'(q.len_out);
      end
      if (q.bram_rd_en && q.bram_we) ovl <= ovl + 1;
      if ((q.bram_rd_en || q.bram_we) && int'(q.bram_addr) >= cur_len) addr_err <= addr_err + 1;
      if (!q.busy && (q.bram_rd_en || q.bram_we || q.bram_addr != '0 || q.bram_wdata != '0))
         idle_err <= idle_err + 1;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic load(input int a, input logic [31:0] v);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = a[9:0];
      pl_data = v;
   endtask
   task automatic load_end();
      @(negedge clk);
      pl_we = 1'b0;
   endtask
   // cycle count is posedges after the accepting edge until deq_valid is seen high
   task automatic run_deq(input string tag, input int lin, input int n, input logic [31:0] exp, input int hold);
      int rs, ws, ls, cyc;
      logic [31:0] d;
      rs = rd_cnt; ws = wr_cnt; ls = lwe_cnt; cur_len = n;
      @(negedge clk);
      q.deq_req = 1'b1;
      q.len_in  = 11'(lin);
      @(negedge clk);
      q.deq_req = 1'b0;
      cyc = 0;
      chk({tag, "_busy"}, 64'(q.busy), 64'(1));
      while (!q.deq_valid && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(2*n+2));
      chk({tag, "_data"}, 64'(q.deq_data), 64'(exp));
      d = q.deq_data;
      for (int i = 0; i < hold; i++) begin
         q.deq_req = i[0];
         @(negedge clk);
         chk({tag, "_hold"}, 64'({q.deq_valid, q.deq_data}), 64'({1'b1, d}));
      end
      q.deq_req   = 1'b0;
      q.deq_ready = 1'b1;
      @(negedge clk);
      q.deq_ready = 1'b0;
      chk({tag, "_done"}, 64'({q.deq_valid, q.busy}), 64'(0));
      @(negedge clk);
      chk({tag, "_idle"}, 64'({q.deq_valid, q.busy}), 64'(0));
      chk({tag, "_reads"}, 64'(rd_cnt - rs), 64'(n));
      chk({tag, "_writes"}, 64'(wr_cnt - ws), 64'(n - 1));
      chk({tag, "_len_we"}, 64'(lwe_cnt - ls), 64'(1));
      chk({tag, "_len_out"}, 64'(lout), 64'(n - 1));
   endtask
   initial begin
      q.deq_req = 1'b0; q.deq_ready = 1'b0; q.len_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'({q.deq_valid, q.deq_empty, q.busy, q.len_we, q.bram_rd_en, q.bram_we}), 64'(0));
      chk("reset_bus", 64'({q.deq_data, q.len_out, q.bram_addr}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      r0 = rd_cnt; w0 = wr_cnt;
      q.deq_req = 1'b1; q.len_in = '0;
      @(negedge clk);
      q.deq_req = 1'b0;
      chk("empty_pulse", 64'({q.deq_empty, q.busy}), 64'(2));
      @(negedge clk);
      chk("empty_end", 64'({q.deq_empty, q.busy}), 64'(0));
      chk("empty_no_bram", 64'(rd_cnt - r0 + wr_cnt - w0), 64'(0));
      load(0, 7); load_end();
      run_deq("len1", 1, 1, 7, 0);
      load(0, 3); load(1, 5); load(2, 9); load(3, 12); load_end();
      run_deq("len4", 4, 4, 3, 5);
      chk("len4_mem", 64'({mem[0][7:0], mem[1][7:0], mem[2][7:0], mem[3][7:0]}), 64'({8'd5, 8'd9, 8'd12, 8'd12}));
      for (int i = 0; i < 1024; i++) load(i, 32'(i));
      load_end();
      run_deq("full", 1024, 1024, 0, 0);
      bad = 0;
      for (int i = 0; i < 1023; i++) if (mem[i] != 32'(i + 1)) bad++;
      chk("full_shift", 64'(bad), 64'(0));
      chk("full_stale", 64'(mem[1023]), 64'(1023));
      run_deq("sat", 2000, 1024, 1, 0);
      chk("sat_mem", 64'({mem[0][15:0], mem[1021][15:0], mem[1022][15:0]}), 64'({16'd2, 16'd1023, 16'd1023}));
      for (int i = 0; i < 8; i++) load(i, 32'(10 + i));
      load_end();
      cur_len = 8; l0 = lwe_cnt;
      @(negedge clk);
      q.deq_req = 1'b1; q.len_in = 11'd8;
      @(negedge clk);
      q.deq_req = 1'b0;
      for (int i = 0; i < 50 && !q.bram_we; i++) @(negedge clk);
      chk("rst_reach_wr", 64'(q.bram_we), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_outs", 64'({q.deq_valid, q.deq_empty, q.busy, q.len_we, q.bram_rd_en, q.bram_we}), 64'(0));
      chk("rst_bus", 64'({q.deq_data, q.bram_addr}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_no_len_we", 64'(lwe_cnt - l0), 64'(0));
      run_deq("after_rst", 2, 2, 10, 0);
      chk("after_rst_mem", 64'(mem[0]), 64'(11));
      chk("overlap", 64'(ovl), 64'(0));
      chk("addr_range", 64'(addr_err), 64'(0));
      chk("idle_bus", 64'(idle_err), 64'(0));
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
